// File: rtl/test_controller_pkg.sv
// Shared definitions for the simulation-harness test controller:
// FSM state encodings and the riscv-tests tohost pass value.
package test_controller_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam int TOHOST_PASS = 1;

endpackage

// File: rtl/test_controller.sv
// Bench sequencer: holds the core in reset for RESET_CYCLES, then snoops the
// data-memory write port for tohost and reports pass / fail / timeout.
module test_controller
  import test_controller_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter int               RESET_CYCLES = 4,
  parameter int               MAX_CYCLES   = 100000,
  parameter logic [XLEN-1:0]  TOHOST_ADDR  = 32'h0000_1000,
  parameter int               CNT_W        = 32
) (
  input  logic              sysClk,
  input  logic              sysRes,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [XLEN-2:0]   fail_code,
  output logic [CNT_W-1:0]  cycles
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [XLEN-1:0]  PASS_VAL  = XLEN'(TOHOST_PASS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             core_reset_q, core_reset_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [XLEN-2:0]  fail_code_q, fail_code_d;
  logic             qual_s;

  assign qual_s = mem_we && (mem_addr == TOHOST_ADDR);

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    cycles_d     = cycles_q;
    core_reset_d = core_reset_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    fail_code_d  = fail_code_q;
    case (state_q)
      ST_HOLD: begin
        hold_d = hold_q + CNT_W'(1);
        if (hold_q == HOLD_LAST) begin
          state_d      = ST_RUN;
          core_reset_d = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RUN: begin
        if (cycles_q != CNT_MAX) begin
          cycles_d = cycles_q + CNT_W'(1);
        end else begin
          cycles_d = cycles_q;
        end
        // A tohost write on the expiry edge wins over the watchdog.
        if (qual_s && (mem_wdata == PASS_VAL)) begin
          state_d      = ST_PASS;
          done_d       = 1'b1;
          pass_d       = 1'b1;
          core_reset_d = 1'b1;
        end else if (qual_s && mem_wdata[0]) begin
          state_d      = ST_FAIL;
          done_d       = 1'b1;
          core_reset_d = 1'b1;
          fail_code_d  = mem_wdata[XLEN-1:1];
        end else if ((MAX_CYCLES != 0) && (cycles_q == RUN_LAST)) begin
          state_d      = ST_TIMEOUT;
          done_d       = 1'b1;
          timeout_d    = 1'b1;
          core_reset_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State and output registers; sysRes clears everything without a clock.
  always_ff @(posedge sysClk or posedge sysRes) begin
    if (sysRes) begin
      state_q      <= ST_HOLD;
      hold_q       <= '0;
      cycles_q     <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cycles_q     <= cycles_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      fail_code_q  <= fail_code_d;
    end
  end

  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign fail_code  = fail_code_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_test_controller.sv
// Self-checking bench: two controllers (watchdog 100 and watchdog disabled)
// share one stimulus stream and are compared against an event-level model.
module tb_test_controller;

  localparam int          RC     = 4;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk;
  logic        sys_res;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  logic        cr_o   [2];
  logic        done_o [2];
  logic        pass_o [2];
  logic        to_o   [2];
  logic [30:0] fc_o   [2];
  logic [31:0] cyc_o  [2];

  int n_checks = 0;
  int n_errors = 0;

  // model state: 0 = watchdog 100, 1 = watchdog disabled
  int          max_c   [2] = '{100, 0};
  int          m_hold  [2];
  int          m_term  [2];   // 0 running/holding, 1 pass, 2 fail, 3 timeout
  longint      m_cyc   [2];
  logic [30:0] m_fc    [2];

  test_controller #(.XLEN(32), .RESET_CYCLES(RC), .MAX_CYCLES(100),
                    .TOHOST_ADDR(TOHOST), .CNT_W(32)) dut (
    .sysClk(clk), .sysRes(sys_res), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_reset(cr_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .timeout(to_o[0]), .fail_code(fc_o[0]), .cycles(cyc_o[0]));

  test_controller #(.XLEN(32), .RESET_CYCLES(RC), .MAX_CYCLES(0),
                    .TOHOST_ADDR(TOHOST), .CNT_W(32)) dut_nowd (
    .sysClk(clk), .sysRes(sys_res), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_reset(cr_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .timeout(to_o[1]), .fail_code(fc_o[1]), .cycles(cyc_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = 0; m_term[k] = 0; m_cyc[k] = 0; m_fc[k] = '0;
    end
  endtask

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      if (m_hold[k] < RC) begin
        m_hold[k]++;
      end else if (m_term[k] == 0) begin
        if (we && a == TOHOST && d == 32'd1) m_term[k] = 1;
        else if (we && a == TOHOST && d[0]) begin
          m_term[k] = 2;
          m_fc[k]   = d[31:1];
        end else if (max_c[k] != 0 && m_cyc[k] == longint'(max_c[k]) - 1) m_term[k] = 3;
        if (m_cyc[k] < 64'hFFFF_FFFF) m_cyc[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("core_reset%0d", k), 64'(cr_o[k]),
                64'((m_hold[k] < RC) || (m_term[k] != 0)));
      check_val($sformatf("done%0d", k),    64'(done_o[k]), 64'(m_term[k] != 0));
      check_val($sformatf("pass%0d", k),    64'(pass_o[k]), 64'(m_term[k] == 1));
      check_val($sformatf("timeout%0d", k), 64'(to_o[k]),   64'(m_term[k] == 3));
      check_val($sformatf("fail_code%0d", k), 64'(fc_o[k]), 64'(m_fc[k]));
      check_val($sformatf("cycles%0d", k),  64'(cyc_o[k]),  64'(m_cyc[k]));
    end
  endtask

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_we = we; mem_addr = a; mem_wdata = d;
    @(posedge clk);
    model_edge(we, a, d);
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0);
  endtask

  task automatic async_reset();
    #2 sys_res = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    sys_res = 1'b0;
  endtask

  logic        r_we;
  logic [31:0] r_a, r_d;

  initial begin
    sys_res = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    model_reset();
    #3 check_all();
    check_val("rst_core_reset", 64'(cr_o[0]), 64'd1);
    check_val("rst_cycles", 64'(cyc_o[0]), 64'd0);
    @(negedge clk);
    sys_res = 1'b0;

    // reset hold and pass at RUN cycle 10
    for (int i = 1; i < RC; i++) begin
      step(1'b0, 32'h0, 32'h0);
      check_val("hold_core_reset", 64'(cr_o[0]), 64'd1);
    end
    step(1'b0, 32'h0, 32'h0);
    check_val("release_core_reset", 64'(cr_o[0]), 64'd0);
    check_val("release_cycles", 64'(cyc_o[0]), 64'd0);
    idle(10);
    step(1'b1, TOHOST, 32'd1);
    check_val("pass_done", 64'(done_o[0]), 64'd1);
    check_val("pass_pass", 64'(pass_o[0]), 64'd1);
    check_val("pass_fc", 64'(fc_o[0]), 64'd0);
    check_val("pass_cycles", 64'(cyc_o[0]), 64'd11);
    check_val("pass_core_reset", 64'(cr_o[0]), 64'd1);
    idle(3);

    // fail with ignored writes, then post-termination write
    async_reset();
    idle(RC + 5);
    step(1'b1, TOHOST, 32'd2);
    check_val("lsb0_ignored", 64'(done_o[0]), 64'd0);
    step(1'b1, 32'h0000_0FFC, 32'd7);
    check_val("wrong_addr_ignored", 64'(done_o[0]), 64'd0);
    step(1'b1, TOHOST, 32'd7);
    check_val("fail_done", 64'(done_o[0]), 64'd1);
    check_val("fail_pass", 64'(pass_o[0]), 64'd0);
    check_val("fail_fc", 64'(fc_o[0]), 64'd3);
    step(1'b1, TOHOST, 32'd5);
    check_val("fail_fc_sticky", 64'(fc_o[0]), 64'd3);

    // timeout on dut, no timeout on the disabled-watchdog instance
    async_reset();
    idle(RC + 100);
    check_val("to_timeout", 64'(to_o[0]), 64'd1);
    check_val("to_done", 64'(done_o[0]), 64'd1);
    check_val("to_cycles", 64'(cyc_o[0]), 64'd100);
    idle(900);
    check_val("nowd_done", 64'(done_o[1]), 64'd0);

    // write on the expiry edge
    async_reset();
    idle(RC + 99);
    step(1'b1, TOHOST, 32'd1);
    check_val("simul_pass", 64'(pass_o[0]), 64'd1);
    check_val("simul_timeout", 64'(to_o[0]), 64'd0);

    // mid-run asynchronous reset
    async_reset();
    idle(RC + 20);
    async_reset();
    check_val("midrst_core_reset", 64'(cr_o[0]), 64'd1);
    check_val("midrst_cycles", 64'(cyc_o[0]), 64'd0);
    idle(RC);
    check_val("midrst_rehold_core_reset", 64'(cr_o[0]), 64'd0);
    check_val("midrst_rehold_cycles", 64'(cyc_o[0]), 64'd0);

    // randomized runs
    for (int run = 0; run < 8; run++) begin
      async_reset();
      for (int i = 0; i < 160; i++) begin
        r_we = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 2))
          0:       r_a = TOHOST;
          1:       r_a = TOHOST - 32'd4;
          default: r_a = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0:       r_d = 32'd1;
          1:       r_d = $urandom & 32'hFFFF_FFFE;
          default: r_d = $urandom | 32'd1;
        endcase
        if (r_a == TOHOST && $urandom_range(0, 1) == 0) r_a = TOHOST;
        step(r_we, r_a, r_d);
        if ($urandom_range(0, 199) == 0) async_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
